// File: rtl/rca_pkg.sv
// Shared types and helpers for the multi-word ripple-carry sequencer.
package rca_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int idx_w(input int c);
    return (c <= 1) ? 1 : $clog2(c);
  endfunction

endpackage

// File: rtl/rca_chunk_add.sv
// Combinational N-bit ripple-carry chunk adder.
// Also exposes the carry into the top bit for overflow detection.
module rca_chunk_add #(
  parameter int N = 64
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co,
  output logic         msb_cin
);

  logic [N:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i])
                  | (c[i] & (x[i] ^ y[i]));
  end

  assign co      = c[N];
  assign msb_cin = c[N-1];

endmodule

// File: rtl/rca_multiword_seq.sv
// W-bit adder sequenced over W/N cycles on one N-bit chunk adder.
// Optional signed overflow output: define RCA_MULTIWORD_SEQ_OVF_EN.
module rca_multiword_seq
  import rca_pkg::*;
#(
  parameter int W = 256,
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
`ifdef RCA_MULTIWORD_SEQ_OVF_EN
  output logic         ovf,
`endif
  output logic         busy
);

  localparam int CHUNKS = W / N;
  localparam int IW     = idx_w(CHUNKS);

  state_e         state;
  state_e         nxt;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic           carry;
  logic [IW-1:0]  idx;
  logic [N-1:0]   x;
  logic [N-1:0]   y;
  logic [N-1:0]   s;
  logic           co;
  logic           last;
`ifdef RCA_MULTIWORD_SEQ_OVF_EN
  logic           mcin;
`endif

  assign last = (idx == IW'(CHUNKS - 1));

  // Mux the active chunk out of the operand registers.
  always_comb begin
    x = '0;
    y = '0;
    for (int i = 0; i < CHUNKS; i++) begin
      if (idx == IW'(i)) begin
        x = a_reg[i*N +: N];
        y = b_reg[i*N +: N];
      end
    end
  end

  rca_chunk_add #(.N(N)) u_add (
    .x       (x),
    .y       (y),
    .ci      (carry),
    .s       (s),
    .co      (co),
`ifdef RCA_MULTIWORD_SEQ_OVF_EN
    .msb_cin (mcin)
`else
    .msb_cin ()
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid)  nxt = RUN;
      RUN:     if (last)      nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef RCA_MULTIWORD_SEQ_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (in_valid) begin
        a_reg <= a;
        b_reg <= b;
        carry <= cin;
        idx   <= '0;
      end
    end else if (state == RUN) begin
      for (int i = 0; i < CHUNKS; i++) begin
        if (idx == IW'(i)) sum[i*N +: N] <= s;
      end
      carry <= co;
      // idx parks on the last chunk rather than wrapping.
      if (last) begin
        cout <= co;
`ifdef RCA_MULTIWORD_SEQ_OVF_EN
        ovf  <= mcin ^ co;
`endif
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rca_multiword_seq.sv
// Self-checking bench for rca_multiword_seq (W=256/N=64 and W=64/N=64).
module tb_rca_multiword_seq;

  localparam int W = 256;
  localparam int N = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         cout, busy;

  logic         iv1, ir1, ov1, or1, ci1, co1, bz1;
  logic [63:0]  a1, b1, s1;
`ifdef RCA_MULTIWORD_SEQ_OVF_EN
  logic         ovf, ovf1;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  rca_multiword_seq #(.W(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout),
`ifdef RCA_MULTIWORD_SEQ_OVF_EN
    .ovf(ovf),
`endif
    .busy(busy)
  );

  rca_multiword_seq #(.W(64), .N(64)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv1), .in_ready(ir1),
    .a(a1), .b(b1), .cin(ci1),
    .out_valid(ov1), .out_ready(or1),
    .sum(s1), .cout(co1),
`ifdef RCA_MULTIWORD_SEQ_OVF_EN
    .ovf(ovf1),
`endif
    .busy(bz1)
  );

  task automatic check(input string tag,
                       input logic [511:0] obs,
                       input logic [511:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++)
      r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Present one operand set for one edge, return edges to out_valid.
  task automatic run_add(input logic [W-1:0] ta,
                         input logic [W-1:0] tb,
                         input logic tc,
                         output int k);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = rnd(); b = rnd(); cin = ~tc;
    k = 0;
    while (!out_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W:0]   ref_full;
    logic [W-1:0] ta, tb, s_hold;
    logic         c_hold, tc;
    logic [W:0]   q[$];
    int           k, cyc, last_cyc, got;
    logic [W-1:0] ones, msb;

    ones = '1;
    msb  = '0;
    msb[W-1] = 1'b1;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
    #12;
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy",      busy,      0);
    check("rst_sum",       sum,       0);
    check("rst_cout",      cout,      0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Carry ripples through every chunk.
    run_add(ones, '0, 1'b1, k);
    check("t1_latency", k,    W / N);
    check("t1_sum",     sum,  0);
    check("t1_cout",    cout, 1);
    check("t1_busy",    busy, 1);
    drain();
    check("t1_idle", in_ready, 1);

    // Output stall with a spurious in_valid pulse.
    ta = {(W/4){4'h1}};
    tb = 2;
    ref_full = {1'b0, ta} + {1'b0, tb};
    run_add(ta, tb, 1'b0, k);
    check("t2_latency", k, W / N);
    s_hold = sum;
    c_hold = cout;
    check("t2_sum", sum, ref_full[W-1:0]);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_valid = 1'b1; a = ones; b = ones;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      check("t2_stall_sum",   sum,       s_hold);
      check("t2_stall_cout",  cout,      c_hold);
      check("t2_stall_ready", in_ready,  0);
      check("t2_stall_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    drain();
    check("t2_idle_ready", in_ready,  1);
    check("t2_idle_valid", out_valid, 0);
    check("t2_held_sum",   sum,       s_hold);

    // Async reset at idx=2.
    a = rnd(); b = rnd(); cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t3_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t3_out_valid", out_valid, 0);
    check("t3_sum",       sum,       0);
    check("t3_cout",      cout,      0);
    check("t3_busy",      busy,      0);
    check("t3_in_ready",  in_ready,  1);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_add(5, 7, 1'b0, k);
    check("t3_sum_12",  sum,  12);
    check("t3_cout_12", cout, 0);
    drain();

    // Back-to-back random traffic.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    got = 0; cyc = 0; last_cyc = -1;
    a = rnd(); b = rnd(); cin = 1'($urandom);
    if (in_ready) q.push_back({1'b0, a} + {1'b0, b} + W'(cin));
    while (got < 8 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid) begin
        ref_full = q.pop_front();
        check("b2b_sum",  sum,  ref_full[W-1:0]);
        check("b2b_cout", cout, ref_full[W]);
        if (last_cyc >= 0)
          check("b2b_interval", cyc - last_cyc, W / N + 2);
        last_cyc = cyc;
        got++;
      end
      a = rnd(); b = rnd(); cin = 1'($urandom);
      if (in_ready) q.push_back({1'b0, a} + {1'b0, b} + W'(cin));
    end
    check("b2b_count", got, 8);
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    while (!in_ready && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      out_ready = 1'b1;
    end
    out_ready = 1'b0;

`ifdef RCA_MULTIWORD_SEQ_OVF_EN
    run_add(ones >> 1, 1, 1'b0, k);
    check("ovf1_ovf",  ovf,  1);
    check("ovf1_cout", cout, 0);
    drain();
    run_add(msb, msb, 1'b0, k);
    check("ovf2_ovf",  ovf,  1);
    check("ovf2_cout", cout, 1);
    check("ovf2_sum",  sum,  0);
    drain();
    run_add(ones, 1, 1'b0, k);
    check("ovf3_ovf",  ovf,  0);
    check("ovf3_cout", cout, 1);
    drain();
    for (int i = 0; i < 4; i++) begin
      ta = rnd(); tb = rnd(); tc = 1'($urandom);
      ref_full = {1'b0, ta} + {1'b0, tb} + W'(tc);
      run_add(ta, tb, tc, k);
      check("ovfr_ovf", ovf,
            (ta[W-1] == tb[W-1]) && (ref_full[W-1] != ta[W-1]));
      drain();
    end
`endif

    // Single-chunk instance.
    a1 = '1; b1 = 64'd1; ci1 = 1'b0; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0; a1 = '0; b1 = '0;
    k = 0;
    while (!ov1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("c1_latency", k,   1);
    check("c1_sum",     s1,  0);
    check("c1_cout",    co1, 1);
    or1 = 1'b1;
    @(posedge clk); #1;
    or1 = 1'b0;
    check("c1_idle", ir1, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
